// File: rtl/mtp_issue_sched.sv
// mtp_issue_sched: multi-threaded issue scheduler.
// Per-thread packet FIFOs feed a round-robin arbiter. The arbiter loads a single
// registered valid/ready issue stage that drives the shared execution unit.
// Optional build macro: MTP_HI_PRIO_EN. When it is defined, a hi_prio input is
// added and eligible high-priority threads are served before the rest. Both
// groups share one round-robin pointer.
module mtp_issue_sched #(
    parameter int NUM_THREADS  = 4,
    parameter int BUFF_DEPTH   = 4,
    parameter int OPCODE_WIDTH = 32,
    localparam int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_THREADS-1:0]              thread_en,
    input  logic [NUM_THREADS-1:0]              flush,
    input  logic [NUM_THREADS-1:0]              opcode_vld,
    input  logic [NUM_THREADS*OPCODE_WIDTH-1:0] opcode0,
    input  logic [NUM_THREADS*OPCODE_WIDTH-1:0] opcode1,
`ifdef MTP_HI_PRIO_EN
    input  logic [NUM_THREADS-1:0]              hi_prio,
`endif
    input  logic                                issue_ready,
    output logic [NUM_THREADS-1:0]              inst_buff_full,
    output logic                                issue_vld,
    output logic [TID_W-1:0]                    issue_tid,
    output logic [OPCODE_WIDTH-1:0]             issue_opcode0,
    output logic [OPCODE_WIDTH-1:0]             issue_opcode1
);

    localparam int PTR_W = $clog2(BUFF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_THREADS-1:0]  w_push;
    logic [NUM_THREADS-1:0]  w_pop;
    logic [NUM_THREADS-1:0]  w_elig;
    logic [NUM_THREADS-1:0]  w_req;
    logic [OPCODE_WIDTH-1:0] w_head_op0 [NUM_THREADS];
    logic [OPCODE_WIDTH-1:0] w_head_op1 [NUM_THREADS];

    logic                    w_grant_vld;
    logic [TID_W-1:0]        w_grant_tid;
    logic                    w_load;
    logic                    w_squash;
    int                      w_sum;
    logic [TID_W-1:0]        w_idx;

    logic [TID_W-1:0]        r_rr_ptr;
    logic                    r_issue_vld;
    logic [TID_W-1:0]        r_issue_tid;
    logic [OPCODE_WIDTH-1:0] r_issue_op0;
    logic [OPCODE_WIDTH-1:0] r_issue_op1;

    // Per-thread packet FIFO: storage, pointers, occupancy and a registered full flag.
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        logic [OPCODE_WIDTH-1:0] r_mem0 [BUFF_DEPTH];
        logic [OPCODE_WIDTH-1:0] r_mem1 [BUFF_DEPTH];
        logic [PTR_W-1:0]        r_wptr;
        logic [PTR_W-1:0]        r_rptr;
        logic [CNT_W-1:0]        r_count;
        logic                    r_full;
        logic [CNT_W-1:0]        w_count_nxt;

        // A flushed thread takes no push this cycle and is kept out of arbitration.
        assign w_push[t]      = opcode_vld[t] && !r_full && !flush[t];
        assign w_elig[t]      = thread_en[t] && (r_count != '0) && !flush[t];
        assign w_pop[t]       = w_load && (w_grant_tid == TID_W'(t));
        assign w_count_nxt    = r_count + CNT_W'(w_push[t]) - CNT_W'(w_pop[t]);
        assign w_head_op0[t]  = r_mem0[r_rptr];
        assign w_head_op1[t]  = r_mem1[r_rptr];
        assign inst_buff_full[t] = r_full;

        // Packet storage carries no reset; validity comes only from the pointers and count.
        always_ff @(posedge clk) begin
            if (w_push[t]) begin
                r_mem0[r_wptr] <= opcode0[t*OPCODE_WIDTH +: OPCODE_WIDTH];
                r_mem1[r_wptr] <= opcode1[t*OPCODE_WIDTH +: OPCODE_WIDTH];
            end
        end

        // Pointers wrap naturally at BUFF_DEPTH. A flush empties the FIFO in one edge.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else if (flush[t]) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                if (w_push[t]) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop[t])  r_rptr <= r_rptr + PTR_W'(1);
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == CNT_W'(BUFF_DEPTH));
            end
        end
    end

    // Request vector: with the priority build, high-priority eligible threads mask the rest.
`ifdef MTP_HI_PRIO_EN
    logic [NUM_THREADS-1:0] w_hi_req;
    assign w_hi_req = w_elig & hi_prio;
    assign w_req    = (|w_hi_req) ? w_hi_req : w_elig;
`else
    assign w_req    = w_elig;
`endif

    // Round-robin pick starting at r_rr_ptr. The scan runs downward so that the
    // closest requester in rotation order is the one that sticks.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_tid = '0;
        w_sum       = 0;
        w_idx       = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            w_sum = int'(r_rr_ptr) + i;
            if (w_sum >= NUM_THREADS) w_sum = w_sum - NUM_THREADS;
            w_idx = TID_W'(w_sum);
            if (w_req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_tid = w_idx;
            end
        end
    end

    assign w_load   = (!r_issue_vld || issue_ready) && w_grant_vld;
    assign w_squash = flush[r_issue_tid];

    // The pointer moves past the granted thread only when the output register loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_rr_ptr <= (w_grant_tid == TID_W'(NUM_THREADS - 1)) ? '0 : w_grant_tid + TID_W'(1);
        end
    end

    // Issue register: load on a free slot, clear after a transfer, or squash a
    // held packet whose thread is flushed while the consumer is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_vld <= 1'b0;
            r_issue_tid <= '0;
            r_issue_op0 <= '0;
            r_issue_op1 <= '0;
        end else if (w_load) begin
            r_issue_vld <= 1'b1;
            r_issue_tid <= w_grant_tid;
            r_issue_op0 <= w_head_op0[w_grant_tid];
            r_issue_op1 <= w_head_op1[w_grant_tid];
        end else if (r_issue_vld && (issue_ready || w_squash)) begin
            r_issue_vld <= 1'b0;
        end
    end

    assign issue_vld     = r_issue_vld;
    assign issue_tid     = r_issue_tid;
    assign issue_opcode0 = r_issue_op0;
    assign issue_opcode1 = r_issue_op1;

endmodule
